// File: rtl/bomb_countdown.sv
// Two-digit BCD countdown timer with a free-running one-second prescaler.
// Responder side of the bomb controller's counter interface.
module bomb_countdown #(
    parameter int CLKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       countLoadN,
    input  logic       countEnable,
    input  logic [7:0] loadValue,
    output logic       OneSecPulse,
    output logic [3:0] countTens,
    output logic [3:0] countOnes,
    output logic       timerEnd
);

    localparam int PRESC_W = $clog2(CLKS_PER_SEC);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_SEC - 1);

    // Controller interface: countLoadN low at an edge loads the digits and
    // restarts the prescaler (overriding everything else); countEnable gates
    // decrements on OneSecPulse; OneSecPulse/timerEnd flow back unconditionally.

    logic [PRESC_W-1:0] prescaler;
    logic               doDecrement;

    function automatic logic [3:0] sat9(input logic [3:0] nibble);
        return (nibble > 4'd9) ? 4'd9 : nibble;
    endfunction

    // Prescaler keeps running while paused so blink timing stays alive.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prescaler   <= '0;
            OneSecPulse <= 1'b0;
        end else if (!countLoadN) begin
            prescaler   <= '0;
            OneSecPulse <= 1'b0;
        end else begin
            OneSecPulse <= (prescaler == PRESC_LAST);
            if (prescaler == PRESC_LAST)
                prescaler <= '0;
            else
                prescaler <= prescaler + 1'b1;
        end
    end

    assign timerEnd    = (countTens == 4'd0) && (countOnes == 4'd0);
    assign doDecrement = countEnable && OneSecPulse && !timerEnd;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            countTens <= 4'd0;
            countOnes <= 4'd0;
        end else if (!countLoadN) begin
            countTens <= sat9(loadValue[7:4]);
            countOnes <= sat9(loadValue[3:0]);
        end else if (doDecrement) begin
            if (countOnes == 4'd0) begin
                countOnes <= 4'd9;
                countTens <= countTens - 4'd1;
            end else begin
                countOnes <= countOnes - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_bomb_countdown.sv
// Directed bench for bomb_countdown with CLKS_PER_SEC = 10; inputs driven and
// outputs sampled on the falling edge.
module tb_bomb_countdown;

    logic       clk;
    logic       resetN;
    logic       countLoadN;
    logic       countEnable;
    logic [7:0] loadValue;
    logic       OneSecPulse;
    logic [3:0] countTens;
    logic [3:0] countOnes;
    logic       timerEnd;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    bomb_countdown #(.CLKS_PER_SEC(10)) dut (
        .clk(clk),
        .resetN(resetN),
        .countLoadN(countLoadN),
        .countEnable(countEnable),
        .loadValue(loadValue),
        .OneSecPulse(OneSecPulse),
        .countTens(countTens),
        .countOnes(countOnes),
        .timerEnd(timerEnd)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_digits(input string tag, input logic [7:0] exp);
        check(tag, {countTens, countOnes}, exp);
        check({tag, "_end"}, {7'd0, timerEnd}, {7'd0, exp == 8'h00});
    endtask

    // driver: one-cycle load strobe, returns at the falling edge after the load edge
    task automatic load(input logic [7:0] v);
        countLoadN = 1'b0;
        loadValue  = v;
        @(negedge clk);
        countLoadN = 1'b1;
    endtask

    // counts falling edges until OneSecPulse is seen, bounded by maxCycles
    task automatic wait_pulse(input int maxCycles, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!OneSecPulse && n <= maxCycles);
    endtask

    initial begin
        int n;
        logic [7:0] e;
        bit first;

        resetN      = 1'b0;
        countLoadN  = 1'b1;
        countEnable = 1'b0;
        loadValue   = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_pulse", {7'd0, OneSecPulse}, 8'd0);
        check_digits("rst_digits", 8'h00);

        // 1: free-running ticks after reset release
        resetN = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            check("t1_pulse", {7'd0, OneSecPulse}, {7'd0, (k % 10) == 0});
            if ((k % 10) == 0) check_digits("t1_digits", 8'h00);
        end

        // 2: count 12 down to 00, then hold
        countEnable = 1'b1;
        load(8'h12);
        check_digits("t2_load", 8'h12);
        check("t2_load_pulse", {7'd0, OneSecPulse}, 8'd0);
        exp_q = {8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        first = 1'b1;
        while (exp_q.size() > 0) begin
            wait_pulse(40, n);
            check("t2_interval", 8'(n), first ? 8'd10 : 8'd9);
            first = 1'b0;
            @(negedge clk);
            e = exp_q.pop_front();
            check_digits("t2_step", e);
        end
        repeat (2) begin
            wait_pulse(40, n);
            @(negedge clk);
            check_digits("t2_hold", 8'h00);
        end

        // 3: pause at 03 for 30 cycles, then resume to 00
        load(8'h05);
        repeat (2) begin
            wait_pulse(40, n);
            @(negedge clk);
        end
        check_digits("t3_pre", 8'h03);
        countEnable = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if ((k % 10) == 0) check_digits("t3_pause", 8'h03);
        end
        countEnable = 1'b1;
        exp_q = {8'h02, 8'h01, 8'h00};
        while (exp_q.size() > 0) begin
            wait_pulse(40, n);
            @(negedge clk);
            e = exp_q.pop_front();
            check_digits("t3_resume", e);
        end

        // 4: nibble saturation and immediate terminal on 00
        load(8'hAF);
        check_digits("t4_sat", 8'h99);
        load(8'h3C);
        check_digits("t4_sat_ones", 8'h39);
        load(8'h00);
        check_digits("t4_zero", 8'h00);

        // 5: load coincident with a tick at 07 wins
        load(8'h07);
        wait_pulse(40, n);
        check("t5_pulse_seen", {7'd0, OneSecPulse}, 8'd1);
        check_digits("t5_at_pulse", 8'h07);
        countLoadN = 1'b0;
        loadValue  = 8'h30;
        @(negedge clk);
        countLoadN = 1'b1;
        check_digits("t5_loaded", 8'h30);
        check("t5_pulse_cleared", {7'd0, OneSecPulse}, 8'd0);
        wait_pulse(40, n);
        check("t5_interval", 8'(n), 8'd10);
        @(negedge clk);
        check_digits("t5_dec", 8'h29);

        // 6: asynchronous reset mid-count at 47
        load(8'h47);
        repeat (3) @(negedge clk);
        check_digits("t6_pre", 8'h47);
        resetN = 1'b0;
        #1;
        check_digits("t6_rst", 8'h00);
        check("t6_rst_pulse", {7'd0, OneSecPulse}, 8'd0);
        @(negedge clk);
        resetN = 1'b1;
        wait_pulse(40, n);
        check("t6_interval", 8'(n), 8'd10);
        @(negedge clk);
        check_digits("t6_after", 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
